// File: rtl/d_grf_sb.sv
// d_grf_sb: dual-write, multi-read general register file with a per-register
// pending-write scoreboard and registered pending count.
`default_nettype none

module d_grf_sb #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NR      = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*DW-1:0] rdata,
  output logic [NR-1:0]    rbusy,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [DW-1:0]   wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [DW-1:0]   wd1,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  output logic [AW:0]     npend
);

  localparam int DEPTH = 1 << AW;
  localparam logic C_BYP = (BYPASS != 0);
  localparam logic C_Z0  = (ZERO_R0 != 0);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic [AW:0]      npend_q;
  logic [AW:0]      npend_d;

  logic w_wr0_ok;
  logic w_wr1_ok;
  logic w_iss_ok;

  assign w_wr0_ok = we0 && !(C_Z0 && (wa0 == '0));
  assign w_wr1_ok = we1 && !(C_Z0 && (wa1 == '0));
  assign w_iss_ok = iss_en && !(C_Z0 && (iss_addr == '0));

  // Issue is applied after the write clears so a same-cycle set wins.
  always_comb begin
    pend_d = pend_q;
    if (we0) pend_d[wa0] = 1'b0;
    if (we1) pend_d[wa1] = 1'b0;
    if (w_iss_ok) pend_d[iss_addr] = 1'b1;
    if (C_Z0) pend_d[0] = 1'b0;
  end

  always_comb begin
    npend_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      npend_d = npend_d + (AW+1)'(pend_q[i]);
    end
  end

  // Port 1 is issued after port 0, so its non-blocking write lands last.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q  <= '0;
      npend_q <= '0;
    end else begin
      if (w_wr0_ok) mem_q[wa0] <= wd0;
      if (w_wr1_ok) mem_q[wa1] <= wd1;
      pend_q  <= pend_d;
      npend_q <= npend_d;
    end
  end

  assign npend = npend_q;

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit0;
    logic          hit1;
    logic [DW-1:0] val;

    assign ra   = raddr[k*AW +: AW];
    assign hit0 = we0 && (wa0 == ra);
    assign hit1 = we1 && (wa1 == ra);

    always_comb begin
      val = mem_q[ra];
      if (C_BYP) begin
        if (hit1)      val = wd1;
        else if (hit0) val = wd0;
      end
      if (C_Z0 && (ra == '0)) val = '0;
    end

    assign rdata[k*DW +: DW] = val;
    assign rbusy[k]          = pend_q[ra] & ~(C_BYP & (hit0 | hit1));
  end

endmodule

`default_nettype wire

// File: tb/tb_d_grf_sb.sv
// tb_d_grf_sb: drives a BYPASS=1 and a BYPASS=0 instance with shared stimulus
// and checks both against an array/queue-level model plus literal vectors.
`default_nettype none

module tb_d_grf_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  raddr;
  logic        we0, we1, iss_en;
  logic [4:0]  wa0, wa1, iss_addr;
  logic [31:0] wd0, wd1;
  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  rbusy_b, rbusy_n;
  logic [5:0]  npend_b, npend_n;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  logic [31:0] mem_m [32];
  bit          pend_m [32];
  int          np_m;

  always #5 clk = ~clk;

  d_grf_sb #(.DW(32), .AW(5), .NR(2), .BYPASS(1), .ZERO_R0(1)) u_byp (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_en(iss_en), .iss_addr(iss_addr), .npend(npend_b)
  );

  d_grf_sb #(.DW(32), .AW(5), .NR(2), .BYPASS(0), .ZERO_R0(1)) u_nob (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_en(iss_en), .iss_addr(iss_addr), .npend(npend_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (byp && we1 && wa1 == ra) return wd1;
    if (byp && we0 && wa0 == ra) return wd0;
    return mem_m[ra];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [4:0] ra);
    if (byp && ((we0 && wa0 == ra) || (we1 && wa1 == ra))) return 1'b0;
    return pend_m[ra];
  endfunction

  // Reference state: what the register file and scoreboard hold after each edge.
  always @(posedge clk) begin : model
    int c;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem_m[i]  = 32'h0;
        pend_m[i] = 1'b0;
      end
      np_m = 0;
    end else begin
      c = 0;
      for (int i = 0; i < 32; i++) c += int'(pend_m[i]);
      np_m = c;
      if (we0 && wa0 != 5'd0) mem_m[wa0] = wd0;
      if (we1 && wa1 != 5'd0) mem_m[wa1] = wd1;
      if (we0) pend_m[wa0] = 1'b0;
      if (we1) pend_m[wa1] = 1'b0;
      if (iss_en && iss_addr != 5'd0) pend_m[iss_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin : compare
    logic [4:0] ra;
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        ra = raddr[k*5 +: 5];
        chk($sformatf("m_rdata_byp%0d", k), rdata_b[k*32 +: 32], exp_rd(1'b1, ra));
        chk($sformatf("m_rdata_nob%0d", k), rdata_n[k*32 +: 32], exp_rd(1'b0, ra));
        chk($sformatf("m_rbusy_byp%0d", k), 32'(rbusy_b[k]), 32'(exp_busy(1'b1, ra)));
        chk($sformatf("m_rbusy_nob%0d", k), 32'(rbusy_n[k]), 32'(exp_busy(1'b0, ra)));
      end
      chk("m_npend_byp", 32'(npend_b), 32'(np_m));
      chk("m_npend_nob", 32'(npend_n), 32'(np_m));
    end
  end

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; raddr = '0; idle();
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_addr = '0;
    nxt();
    chk_on = 1'b1;
    nxt();
    reset = 1'b0;

    // Post-reset sweep of all addresses
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      @(negedge clk);
      chk("rst_rdata0", rdata_b[31:0], 32'h0);
      chk("rst_rdata1", rdata_n[63:32], 32'h0);
      chk("rst_rbusy", 32'(rbusy_b | rbusy_n), 32'h0);
      chk("rst_npend", 32'(npend_b), 32'h0);
      nxt();
    end

    // Same-cycle bypass of a single write
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAAAA5555; raddr = {5'd0, 5'd3};
    @(negedge clk);
    chk("byp_wr3", rdata_b[31:0], 32'hAAAA5555);
    chk("nob_wr3", rdata_n[31:0], 32'h0);
    nxt(); idle();
    @(negedge clk);
    chk("byp_rd3", rdata_b[31:0], 32'hAAAA5555);
    chk("nob_rd3", rdata_n[31:0], 32'hAAAA5555);
    nxt();

    // Dual write collision: port 1 wins
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11; we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
    raddr = {5'd7, 5'd7};
    @(negedge clk);
    chk("byp_coll", rdata_b[63:32], 32'h22);
    nxt(); idle();
    @(negedge clk);
    chk("nob_coll_store", rdata_n[31:0], 32'h22);
    nxt();

    // Register zero
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; raddr = {5'd0, 5'd0};
    @(negedge clk);
    chk("r0_byp", rdata_b[31:0], 32'h0);
    nxt(); idle();
    iss_en = 1'b1; iss_addr = 5'd0;
    @(negedge clk);
    chk("r0_store", rdata_n[31:0], 32'h0);
    nxt(); idle(); nxt();
    @(negedge clk);
    chk("r0_npend", 32'(npend_b), 32'h0);
    chk("r0_rbusy", 32'(rbusy_b[0]), 32'h0);
    nxt();

    // Issue/write race on address 5
    iss_en = 1'b1; iss_addr = 5'd5; raddr = {5'd0, 5'd5};
    nxt();
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h55;
    @(negedge clk);
    chk("race_busy_byp", 32'(rbusy_b[0]), 32'h0);
    chk("race_busy_nob", 32'(rbusy_n[0]), 32'h1);
    nxt(); idle();
    @(negedge clk);
    chk("race_pend", 32'(rbusy_n[0]), 32'h1);
    chk("race_npend", 32'(npend_b), 32'h1);
    chk("race_data", rdata_n[31:0], 32'h55);
    nxt();
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h66;
    nxt(); idle();
    @(negedge clk);
    chk("clr_busy", 32'(rbusy_n[0]), 32'h0);
    chk("clr_npend_lag", 32'(npend_n), 32'h1);
    nxt();
    @(negedge clk);
    chk("clr_npend", 32'(npend_b), 32'h0);
    chk("clr_data", rdata_b[31:0], 32'h66);
    nxt();

    // Mid-sequence reset abandons pending state
    for (int a = 1; a <= 3; a++) begin
      iss_en = 1'b1; iss_addr = 5'(a);
      nxt();
    end
    idle(); nxt(); nxt();
    raddr = {5'd2, 5'd1};
    @(negedge clk);
    chk("pre_rst_npend", 32'(npend_b), 32'h3);
    chk("pre_rst_busy", 32'(rbusy_n), 32'h3);
    nxt();
    reset = 1'b1; iss_en = 1'b1; iss_addr = 5'd4; we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hDEAD;
    nxt();
    reset = 1'b0; idle();
    @(negedge clk);
    chk("post_rst_npend", 32'(npend_b), 32'h0);
    chk("post_rst_busy", 32'(rbusy_b | rbusy_n), 32'h0);
    nxt();
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      @(negedge clk);
      chk("post_rst_data", rdata_n[31:0], 32'h0);
      chk("post_rst_pend", 32'(rbusy_n[1]), 32'h0);
      nxt();
    end

    // Mixed traffic on a small address window, checked by the model
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 59) == 0);
      we0      = 1'($urandom_range(0, 1));
      wa0      = 5'($urandom_range(0, 7));
      wd0      = $urandom;
      we1      = 1'($urandom_range(0, 1));
      wa1      = 5'($urandom_range(0, 7));
      wd1      = $urandom;
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = 5'($urandom_range(0, 7));
      raddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      nxt();
    end
    reset = 1'b0; idle();
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
